// File: rtl/reg_file_sb.sv
// Register file with one write port, two bypassed combinational read ports and a
// per-register pending-write scoreboard used by issue/decode for hazard stalls.
module reg_file_sb #(
    parameter int  WIDTH    = 16,
    parameter int  DEPTH    = 4,
    parameter int  ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [AW-1:0]    RS,
    input  logic [AW-1:0]    RT,
    output logic [WIDTH-1:0] ReadRS,
    output logic [WIDTH-1:0] ReadRT,
    input  logic [AW-1:0]    RD,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             RegWrite,
    input  logic             Reserve,
    input  logic [AW-1:0]    ReserveRD,
    output logic             BusyRS,
    output logic             BusyRT,
    output logic             AnyBusy
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pending;

    logic             w_wr_ok;
    logic             w_rsv_ok;
    logic             w_rs_ok;
    logic             w_rt_ok;
    logic             w_rs_hit;
    logic             w_rt_hit;
    logic [WIDTH-1:0] w_rs_data;
    logic [WIDTH-1:0] w_rt_data;
    logic             w_rs_pend;
    logic             w_rt_pend;

    // An address names real storage only if it is in range and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        addr_ok = (int'(addr) < DEPTH) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    assign w_wr_ok  = RegWrite & addr_ok(RD);
    assign w_rsv_ok = Reserve  & addr_ok(ReserveRD);
    assign w_rs_ok  = addr_ok(RS);
    assign w_rt_ok  = addr_ok(RT);
    assign w_rs_hit = w_wr_ok & (RD == RS);
    assign w_rt_hit = w_wr_ok & (RD == RT);

    // NOTE: the array is reset like ordinary flops because reads after reset must return 0;
    // this keeps it out of RAM macros, which is acceptable at this small depth.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking assignments so every element samples pre-edge inputs.
                if (w_wr_ok && (RD == AW'(i))) begin
                    r_regs[i] <= WriteData;
                end
                // A new reservation outranks a retiring writeback to the same register.
                if (w_rsv_ok && (ReserveRD == AW'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (w_wr_ok && (RD == AW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        w_rs_pend = 1'b0;
        w_rt_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RS == AW'(i)) begin
                w_rs_data = r_regs[i];
                w_rs_pend = r_pending[i];
            end
            if (RT == AW'(i)) begin
                w_rt_data = r_regs[i];
                w_rt_pend = r_pending[i];
            end
        end
    end

    assign ReadRS  = !w_rs_ok ? '0 : (w_rs_hit ? WriteData : w_rs_data);
    assign ReadRT  = !w_rt_ok ? '0 : (w_rt_hit ? WriteData : w_rt_data);
    assign BusyRS  = w_rs_ok & w_rs_pend & ~w_rs_hit;
    assign BusyRT  = w_rt_ok & w_rt_pend & ~w_rt_hit;
    assign AnyBusy = |r_pending;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with one write port, two combinational read ports, same-cycle write-through bypass and a per-register pending-write scoreboard. It replaces the fixed 4 x 16-bit register file in the datapath. Issue logic reserves a destination register when a multi-cycle producer is launched. Decode uses the busy outputs to stall until the matching writeback clears the reservation.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 4, number of registers (>= 2, need not be a power of two)
- ZERO_REG, 0, if 1 register 0 always reads 0 and ignores writes and reservations
- AW (localparam), clog2(DEPTH), address width used by all address ports
- Clock  in  1  single clock, all state updates on rising edge
- ResetN  in  1  asynchronous, active-low reset
- RS  in  AW  read address A
- RT  in  AW  read address B
- ReadRS  out  WIDTH  data at RS (combinational, bypassed)
- ReadRT  out  WIDTH  data at RT (combinational, bypassed)
- RD  in  AW  write address
- WriteData  in  WIDTH  write data
- RegWrite  in  1  write enable
- Reserve  in  1  mark ReserveRD as pending
- ReserveRD  in  AW  register to reserve
- BusyRS  out  1  RS has a pending write not satisfied this cycle
- BusyRT  out  1  RT has a pending write not satisfied this cycle
- AnyBusy  out  1  OR of all pending bits (registered state, no bypass)

## Operation
- State: Registers[DEPTH] of WIDTH bits; Pending[DEPTH] bits.
- Reset (ResetN low, async): all Registers = 0, all Pending = 0, immediately. The outputs then are ReadRS = ReadRT = 0, BusyRS = BusyRT = AnyBusy = 0.
- Write: at posedge with RegWrite = 1 and RD valid, Registers[RD] <= WriteData and Pending[RD] <= 0.
- Reserve: at posedge with Reserve = 1 and ReserveRD valid, Pending[ReserveRD] <= 1.
- Simultaneous write and reserve of the same register: Pending ends 1, because the new producer wins. The data write still occurs.
- Read bypass: if RegWrite = 1 and RD == RS (valid, not zero-reg), ReadRS = WriteData; otherwise ReadRS = Registers[RS]. ReadRT follows the same rule.
- Busy: BusyRS = Pending[RS] & ~(RegWrite & RD == RS). A writeback in the same cycle satisfies the hazard. BusyRT follows the same rule.
- Reserve in the current cycle does not affect the current-cycle Busy outputs. They reflect state before the edge.
- ZERO_REG = 1: address 0 reads 0 and Busy is 0. Writes and reservations to address 0 are dropped.
- Out-of-range address (>= DEPTH): reads return 0 and Busy is 0. Writes and reservations are dropped with no side effects.
- Writes without a prior reservation are legal. Reserving an already pending register is legal and leaves it at 1.

## Timing
- Write latency: the data is visible on the read ports in the same cycle through the bypass. From the array it is visible from the next cycle on.
- Reservation latency: Busy asserts on the cycle after Reserve is sampled.
- Release: Busy deasserts in the same cycle as the matching RegWrite, through the bypass. Pending is clear from the next edge.
- AnyBusy is derived only from registered state. It updates one cycle after any reserve or write.
- Reset asserted mid-operation clears all state at once, regardless of Clock. The first edge after ResetN rises performs normal writes and reserves.
- No combinational path from Reserve or ReserveRD to any output.

## Test plan
- Reset then read: pulse ResetN low, RS = 1, RT = 3 -> ReadRS = ReadRT = 0x0000, BusyRS = BusyRT = AnyBusy = 0.
- Write and bypass: RegWrite = 1, RD = 2, WriteData = 0xBEEF, RS = 2 in the same cycle -> ReadRS = 0xBEEF before the edge. After the edge, with RegWrite = 0, ReadRS = 0xBEEF.
- Scoreboard: Reserve with ReserveRD = 1 at cycle 0 -> BusyRS = 1 (RS = 1) and AnyBusy = 1 at cycle 1. At cycle 3, RegWrite RD = 1 with 0x1234 -> BusyRS = 0 and ReadRS = 0x1234 in cycle 3. AnyBusy = 0 at cycle 4.
- Collision: Pending[3] = 1, then RegWrite RD = 3 together with Reserve ReserveRD = 3 -> Registers[3] is updated and BusyRT (RT = 3) = 1 on the next cycle.
- ZERO_REG = 1 and DEPTH = 5 (AW = 3): write 0xFFFF to RD = 0 and to RD = 6, reserve 0 -> reads at 0 and 6 return 0, Busy = 0, AnyBusy = 0.
- Async reset mid-stream: reserve registers 0-3 and write nonzero data, then drop ResetN between edges -> all outputs are 0 before the next rising Clock.
